// File: rtl/conv_pkg.sv
// Shared types and the pixel normalisation arithmetic for the convolution
// result streamer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int ADDR_W   = 15;
    localparam int RESULT_W = 16;

    // Offset-subtract in 17 bits so that the full signed range cannot wrap,
    // then clamp negatives to zero and saturate to 'depth' bits.
    function automatic logic [RESULT_W-1:0] norm_pixel(
        input logic [RESULT_W-1:0] data,
        input logic [RESULT_W-1:0] offset,
        input int unsigned         shift,
        input int unsigned         depth
    );
        logic [RESULT_W:0]   diff;
        logic [RESULT_W:0]   scaled;
        logic [RESULT_W:0]   max_val;
        logic [RESULT_W-1:0] result;
        diff    = {data[RESULT_W-1], data} - {offset[RESULT_W-1], offset};
        scaled  = diff >> shift;
        max_val = ((RESULT_W+1)'(1) << depth) - (RESULT_W+1)'(1);
        if (diff[RESULT_W]) begin
            result = '0;
        end else if (scaled > max_val) begin
            result = RESULT_W'(max_val);
        end else begin
            result = RESULT_W'(scaled);
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO; head is the oldest entry whenever
// count is non-zero. Simultaneous push and pop is allowed when full.
module stream_fifo2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/conv_result_streamer.sv
// Reads convolution results from memory, normalises each word and streams the
// pixels out in raster order with end-of-line / end-of-frame markers.
module conv_result_streamer
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH   = 128,
    parameter int IMAGE_HEIGHT  = 128,
    parameter int KERNAL_WIDTH  = 3,
    parameter int KERNAL_HEIGHT = 3,
    parameter int COLOUR_DEPTH  = 8,
    parameter int SHIFT         = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       addr_conv,
    input  logic [RESULT_W-1:0]     offset,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [RESULT_W-1:0]     mem_rd_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [COLOUR_DEPTH-1:0] pix_data,
    output logic                    pix_eol,
    output logic                    pix_eof,
    output logic                    busy,
    output logic                    done
);

    localparam int OUT_W = IMAGE_WIDTH - KERNAL_WIDTH + 1;
    localparam int OUT_H = IMAGE_HEIGHT - KERNAL_HEIGHT + 1;
    localparam int N     = OUT_W * OUT_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int COL_W = $clog2(OUT_W + 1);
    localparam int ROW_W = $clog2(OUT_H + 1);
    localparam int FW    = COLOUR_DEPTH + 2;

    state_t              state_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [RESULT_W-1:0] offset_reg;
    logic [CNT_W-1:0]    rd_cnt_reg;
    logic                inflight_reg;
    logic [COL_W-1:0]    push_col_reg;
    logic [ROW_W-1:0]    push_row_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [1:0]              fifo_count;
    logic [FW-1:0]           fifo_head;
    logic                    pop;
    logic                    rd_en;
    logic [2:0]              occupancy;
    logic                    push_eol;
    logic                    push_eof;
    logic [COLOUR_DEPTH-1:0] push_pixel;
    logic [FW-1:0]           push_word;

    // A read is only issued when its result is sure to find a FIFO slot,
    // counting the read still in flight and any pop happening this cycle.
    always_comb begin
        pop       = (fifo_count != 2'd0) && pix_ready;
        occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg};
        rd_en     = (state_reg == RUN) && (pop ? (occupancy < 3'd3) : (occupancy < 3'd2));
    end

    assign push_eol   = (push_col_reg == COL_W'(OUT_W - 1));
    assign push_eof   = push_eol && (push_row_reg == ROW_W'(OUT_H - 1));
    assign push_pixel = COLOUR_DEPTH'(norm_pixel(mem_rd_data, offset_reg, SHIFT, COLOUR_DEPTH));
    assign push_word  = {push_eol, push_eof, push_pixel};

    stream_fifo2 #(
        .W(FW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight_reg),
        .push_data(push_word),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            offset_reg   <= '0;
            rd_cnt_reg   <= '0;
            inflight_reg <= 1'b0;
            push_col_reg <= '0;
            push_row_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
            // Marker position follows the pushed word, i.e. the read index.
            if (inflight_reg) begin
                if (push_eol) begin
                    push_col_reg <= '0;
                    push_row_reg <= push_row_reg + ROW_W'(1);
                end else begin
                    push_col_reg <= push_col_reg + COL_W'(1);
                end
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg     <= addr_conv;
                        offset_reg   <= offset;
                        rd_cnt_reg   <= '0;
                        push_col_reg <= '0;
                        push_row_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
                        if (rd_cnt_reg == CNT_W'(N - 1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_head[FW-2]) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = base_reg + ADDR_W'(rd_cnt_reg);
    assign pix_valid = (fifo_count != 2'd0);
    assign pix_data  = pix_valid ? fifo_head[COLOUR_DEPTH-1:0] : '0;
    assign pix_eol   = pix_valid && fifo_head[FW-1];
    assign pix_eof   = pix_valid && fifo_head[FW-2];
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer on an 8x8 image with a 3x3 kernel
// (6x6 = 36 output pixels), with a 1-cycle latency memory model.
module tb_conv_result_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] addr_conv = '0;
    logic [15:0] offset = '0;
    logic        pix_ready = 1'b0;
    logic [15:0] mem_rd_data = '0;

    logic        mem_rd_en, pix_valid, pix_eol, pix_eof, busy, done;
    logic [14:0] mem_addr;
    logic [7:0]  pix_data;
    logic        mem_rd_en_s4, pix_valid_s4, pix_eol_s4, pix_eof_s4, busy_s4, done_s4;
    logic [14:0] mem_addr_s4;
    logic [7:0]  pix_data_s4;

    always #5 clk = ~clk;

    conv_result_streamer #(
        .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .KERNAL_WIDTH(3), .KERNAL_HEIGHT(3),
        .COLOUR_DEPTH(8), .SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .addr_conv(addr_conv), .offset(offset),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .done(done)
    );

    // Same stimulus with SHIFT=4; its timing matches dut, so it shares the memory model.
    conv_result_streamer #(
        .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .KERNAL_WIDTH(3), .KERNAL_HEIGHT(3),
        .COLOUR_DEPTH(8), .SHIFT(4)
    ) dut_s4 (
        .clk(clk), .reset(reset), .start(start), .addr_conv(addr_conv), .offset(offset),
        .mem_rd_en(mem_rd_en_s4), .mem_addr(mem_addr_s4), .mem_rd_data(mem_rd_data),
        .pix_valid(pix_valid_s4), .pix_ready(pix_ready), .pix_data(pix_data_s4),
        .pix_eol(pix_eol_s4), .pix_eof(pix_eof_s4), .busy(busy_s4), .done(done_s4)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: mode 0 returns a constant word, mode 1 returns the address low byte.
    int          mem_mode = 0;
    logic [15:0] mem_word = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_mode == 0) ? mem_word : {8'h00, mem_addr[7:0]};
        else mem_rd_data <= 16'h0000;
    end

    logic [14:0] rd_q[$];
    logic [9:0]  pix_q[$];
    logic [7:0]  pix4_q[$];
    int          hs_q[$];
    int          done_cnt = 0, done_cyc = 0, issued = 0, accepted = 0;
    int          flow_err = 0, stab_err = 0;
    logic        done_busy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_pix = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            issued = 0;
            accepted = 0;
        end else begin
            if (prev_stall && (!pix_valid || {pix_eol, pix_eof, pix_data} !== prev_pix)) stab_err++;
            if (mem_rd_en) begin
                if ((issued - accepted) - ((pix_valid && pix_ready) ? 1 : 0) >= 2) flow_err++;
                rd_q.push_back(mem_addr);
                issued++;
            end
            if (pix_valid && pix_ready) begin
                pix_q.push_back({pix_eol, pix_eof, pix_data});
                pix4_q.push_back(pix_data_s4);
                hs_q.push_back(cyc);
                accepted++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_busy = busy;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_pix = {pix_eol, pix_eof, pix_data};
        end
    end

    task automatic run_frame(input logic [14:0] base, input logic [15:0] off, input int rmode,
                             input int stall_at, input int restart_at,
                             output int start_cyc, output bit finished);
        int stall_left;
        bit stalled;
        rd_q.delete(); pix_q.delete(); pix4_q.delete(); hs_q.delete();
        done_cnt = 0; issued = 0; accepted = 0; flow_err = 0; stab_err = 0;
        stall_left = 0; stalled = 0; finished = 0;
        @(posedge clk); #1;
        addr_conv = base; offset = off; start = 1'b1; start_cyc = cyc;
        pix_ready = (rmode == 0);
        for (int i = 0; i < 3000 && !finished; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (restart_at > 0 && accepted == restart_at) begin
                start = 1'b1; addr_conv = 15'h1234; offset = 16'h7777;
            end
            if (rmode == 0) begin
                pix_ready = 1'b1;
            end else begin
                if (!stalled && accepted >= stall_at) begin stalled = 1; stall_left = 10; end
                if (stall_left > 0) begin pix_ready = 1'b0; stall_left--; end
                else pix_ready = 1'($urandom_range(0, 1));
            end
            if (done_cnt > 0) finished = 1;
        end
        start = 1'b0;
        pix_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // Check count, read addresses, pixel data and markers for a frame of
    // address-pattern words starting at base (offset 0, so pixel = addr low byte).
    task automatic check_pattern_frame(input string name, input logic [14:0] base, input bit finished);
        logic [14:0] a;
        logic [9:0]  exp;
        total_cnt++;
        if (finished !== 1'b1) $display("FAIL %s_done: got %0d expected 1", name, finished);
        else pass_cnt++;
        total_cnt++;
        if (pix_q.size() != 36 || rd_q.size() != 36)
            $display("FAIL %s_count: got %0d pixels %0d reads expected 36 36", name, pix_q.size(), rd_q.size());
        else pass_cnt++;
        for (int i = 0; i < 36 && i < pix_q.size() && i < rd_q.size(); i++) begin
            a = base + 15'(i);
            exp = {(i % 6 == 5), (i == 35), a[7:0]};
            total_cnt++;
            if (rd_q[i] !== a || pix_q[i] !== exp)
                $display("FAIL %s_px%0d: got addr %h pix %h expected addr %h pix %h", name, i, rd_q[i], pix_q[i], a, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); @(negedge clk);
            total_cnt++;
            if ({busy, done, pix_valid, mem_rd_en} !== 4'b0000)
                $display("FAIL reset_outputs c%0d: got %b expected 0000", c, {busy, done, pix_valid, mem_rd_en});
            else pass_cnt++;
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({busy, done, pix_valid, mem_rd_en} !== 4'b0000)
                $display("FAIL idle_outputs c%0d: got %b expected 0000", c, {busy, done, pix_valid, mem_rd_en});
            else pass_cnt++;
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int sc; bit fin; logic [9:0] exp;
        mem_mode = 0; mem_word = 16'h0100;
        run_frame(15'h4000, 16'h0010, 0, 0, 0, sc, fin);
        total_cnt++;
        if (fin !== 1'b1 || pix_q.size() != 36 || rd_q.size() != 36)
            $display("FAIL basic_count: got fin %0d pixels %0d reads %0d expected 1 36 36", fin, pix_q.size(), rd_q.size());
        else pass_cnt++;
        for (int i = 0; i < pix_q.size() && i < 36; i++) begin
            exp = {(i % 6 == 5), (i == 35), 8'hF0};
            total_cnt++;
            if (pix_q[i] !== exp || pix4_q[i] !== 8'h0F)
                $display("FAIL basic_px%0d: got %h shift4 %h expected %h shift4 0f", i, pix_q[i], pix4_q[i], exp);
            else pass_cnt++;
        end
        if (fin && hs_q.size() == 36 && rd_q.size() == 36) begin
            total_cnt++;
            if (rd_q[0] !== 15'h4000 || rd_q[35] !== 15'h4023)
                $display("FAIL basic_addr: got first %h last %h expected 4000 4023", rd_q[0], rd_q[35]);
            else pass_cnt++;
            total_cnt++;
            if (hs_q[0] - sc !== 3) $display("FAIL basic_latency: got %0d expected 3", hs_q[0] - sc);
            else pass_cnt++;
            total_cnt++;
            if (hs_q[35] - hs_q[0] !== 35) $display("FAIL basic_throughput: got %0d expected 35", hs_q[35] - hs_q[0]);
            else pass_cnt++;
            total_cnt++;
            if (done_cnt !== 1 || done_cyc !== hs_q[35] + 1 || done_busy !== 1'b0)
                $display("FAIL basic_done: got pulses %0d at +%0d busy %b expected 1 at +1 busy 0",
                         done_cnt, done_cyc - hs_q[35], done_busy);
            else pass_cnt++;
        end
        $display("test_basic done");
    endtask

    task automatic test_saturation();
        int sc; bit fin;
        logic [15:0] words [3] = '{16'h0005, 16'h7FFF, 16'h0800};
        logic [15:0] offs  [3] = '{16'h0010, 16'h8000, 16'h0000};
        logic [7:0]  exp0  [3] = '{8'h00, 8'hFF, 8'hFF};
        logic [7:0]  exp4  [3] = '{8'h00, 8'hFF, 8'h80};
        for (int k = 0; k < 3; k++) begin
            mem_mode = 0; mem_word = words[k];
            run_frame(15'h4000, offs[k], 0, 0, 0, sc, fin);
            total_cnt++;
            if (pix_q.size() != 36) $display("FAIL sat%0d_count: got %0d expected 36", k, pix_q.size());
            else pass_cnt++;
            if (pix_q.size() == 36) begin
                total_cnt++;
                if (pix_q[0][7:0] !== exp0[k] || pix_q[35][7:0] !== exp0[k] || pix4_q[17] !== exp4[k])
                    $display("FAIL sat%0d_value: got %h %h shift4 %h expected %h shift4 %h", k,
                             pix_q[0][7:0], pix_q[35][7:0], pix4_q[17], exp0[k], exp4[k]);
                else pass_cnt++;
            end
        end
        $display("test_saturation done");
    endtask

    task automatic test_backpressure();
        int sc; bit fin;
        mem_mode = 1;
        run_frame(15'h4000, 16'h0000, 1, 15, 0, sc, fin);
        check_pattern_frame("bp", 15'h4000, fin);
        total_cnt++;
        if (flow_err !== 0) $display("FAIL bp_read_gating: got %0d violations expected 0", flow_err);
        else pass_cnt++;
        total_cnt++;
        if (stab_err !== 0) $display("FAIL bp_stability: got %0d violations expected 0", stab_err);
        else pass_cnt++;
        $display("test_backpressure done");
    endtask

    task automatic test_wrap();
        int sc; bit fin;
        mem_mode = 1;
        run_frame(15'h7FF0, 16'h0000, 0, 0, 0, sc, fin);
        check_pattern_frame("wrap", 15'h7FF0, fin);
        $display("test_wrap done");
    endtask

    task automatic test_restart_ignored();
        int sc; bit fin;
        mem_mode = 1;
        run_frame(15'h4000, 16'h0000, 0, 0, 8, sc, fin);
        check_pattern_frame("restart", 15'h4000, fin);
        $display("test_restart_ignored done");
    endtask

    task automatic test_reset_abort();
        int sc; bit fin; bit reached;
        mem_mode = 1; reached = 0;
        done_cnt = 0; accepted = 0;
        @(posedge clk); #1;
        addr_conv = 15'h4000; offset = 16'h0000; start = 1'b1; pix_ready = 1'b1;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (accepted >= 10) reached = 1;
        end
        total_cnt++;
        if (reached !== 1'b1) $display("FAIL abort_reach: got %0d expected 1", reached);
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, pix_valid, mem_rd_en, pix_eol, pix_eof} !== 6'b0 || pix_data !== 8'h00 || mem_addr !== 15'h0000)
            $display("FAIL abort_outputs: got %b data %h addr %h expected 000000 data 00 addr 0000",
                     {busy, done, pix_valid, mem_rd_en, pix_eol, pix_eof}, pix_data, mem_addr);
        else pass_cnt++;
        done_cnt = 0;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (done_cnt !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt);
        else pass_cnt++;
        run_frame(15'h4000, 16'h0000, 0, 0, 0, sc, fin);
        check_pattern_frame("after_abort", 15'h4000, fin);
        $display("test_reset_abort done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_wrap();
        test_restart_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
